// File: rtl/iob_pbus_arbiter_pkg.sv
// Shared definitions for the IOb pbus arbiter: FSM state encoding and grant-index width helper.
package iob_pbus_arbiter_pkg;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] WAIT_READY  = 2'd1;
  localparam logic [1:0] WAIT_RVALID = 2'd2;

  // Grant index width; never below one bit so a 2-manager build still has a real index.
  function automatic int calc_n_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_pbus_arb_sel.sv
// Combinational priority select: first valid manager at or after rr_ptr_i, wrapping modulo N.
module iob_pbus_arb_sel #(
  parameter int N   = 2,
  parameter int N_W = 1
) (
  input  logic [N-1:0]   valid_i,
  input  logic [N_W-1:0] rr_ptr_i,
  output logic [N_W-1:0] gnt_o,
  output logic           any_valid_o
);

  int             w_pos;
  logic [N_W-1:0] w_idx;

  // With nothing valid the index rests on rr_ptr_i so the forwarded payload is deterministic.
  always_comb begin
    gnt_o       = rr_ptr_i;
    any_valid_o = 1'b0;
    w_pos       = 0;
    w_idx       = '0;
    for (int i = 0; i < N; i++) begin
      w_pos = int'(rr_ptr_i) + i;
      if (w_pos >= N) w_pos = w_pos - N;
      w_idx = N_W'(w_pos);
      if (!any_valid_o && valid_i[w_idx]) begin
        gnt_o       = w_idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iob_pbus_arbiter.sv
// Shares one IOb pbus subordinate port among N_MANAGERS managers, holding the grant until completion.
// Define IOB_PBUS_ARBITER_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module iob_pbus_arbiter
  import iob_pbus_arbiter_pkg::*;
#(
  parameter int N_MANAGERS = 2,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  localparam int N_W       = calc_n_w(N_MANAGERS),
  localparam int STRB_W    = DATA_W / 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [N_MANAGERS-1:0]          m_iob_valid_i,
  input  logic [N_MANAGERS*ADDR_W-1:0]   m_iob_addr_i,
  input  logic [N_MANAGERS*DATA_W-1:0]   m_iob_wdata_i,
  input  logic [N_MANAGERS*STRB_W-1:0]   m_iob_wstrb_i,
  output logic [N_MANAGERS-1:0]          m_iob_rvalid_o,
  output logic [N_MANAGERS*DATA_W-1:0]   m_iob_rdata_o,
  output logic [N_MANAGERS-1:0]          m_iob_ready_o,
  output logic                           s_iob_valid_o,
  output logic [ADDR_W-1:0]              s_iob_addr_o,
  output logic [DATA_W-1:0]              s_iob_wdata_o,
  output logic [STRB_W-1:0]              s_iob_wstrb_o,
  input  logic                           s_iob_rvalid_i,
  input  logic [DATA_W-1:0]              s_iob_rdata_i,
  input  logic                           s_iob_ready_i,
  output logic [N_W-1:0]                 grant_o,
  output logic                           busy_o
);

  logic [1:0]     r_state;
  logic [N_W-1:0] r_owner;
  logic [1:0]     w_nxt_state;
  logic [N_W-1:0] w_rr_ptr;
  logic [N_W-1:0] w_sel_gnt;
  logic           w_any_valid;
  logic [N_W-1:0] w_cur;
  logic           w_cur_valid;
  logic           w_cur_wr;
  logic           w_fwd;
  logic           w_start;
  logic           w_done;
  logic           w_route_rv;

  iob_pbus_arb_sel #(
    .N   (N_MANAGERS),
    .N_W (N_W)
  ) u_sel (
    .valid_i     (m_iob_valid_i),
    .rr_ptr_i    (w_rr_ptr),
    .gnt_o       (w_sel_gnt),
    .any_valid_o (w_any_valid)
  );

  // Arbitration only happens in IDLE; every other state is locked to the recorded owner.
  assign w_cur       = (r_state == IDLE) ? w_sel_gnt : r_owner;
  assign w_cur_valid = m_iob_valid_i[w_cur];
  assign w_cur_wr    = |m_iob_wstrb_i[int'(w_cur)*STRB_W +: STRB_W];
  assign w_fwd       = (r_state != WAIT_RVALID) && w_cur_valid;

  always_comb begin
    w_nxt_state = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_route_rv  = 1'b0;
    if (r_state == WAIT_RVALID) begin
      if (s_iob_rvalid_i) begin
        w_done      = 1'b1;
        w_route_rv  = 1'b1;
        w_nxt_state = IDLE;
      end
    end else if (w_cur_valid) begin
      w_start = 1'b1;
      if (!s_iob_ready_i) begin
        w_nxt_state = WAIT_READY;
      end else if (w_cur_wr) begin
        w_done      = 1'b1;
        w_nxt_state = IDLE;
      end else if (s_iob_rvalid_i) begin
        w_done      = 1'b1;
        w_route_rv  = 1'b1;
        w_nxt_state = IDLE;
      end else begin
        w_nxt_state = WAIT_RVALID;
      end
    end else begin
      // Owner withdrew before ready: abandon without touching the round-robin pointer.
      w_nxt_state = IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_start) r_owner <= w_cur;
    end
  end

`ifdef IOB_PBUS_ARBITER_RR_EN
  logic [N_W-1:0] r_rr_ptr;
  logic [N_W-1:0] w_rr_next;

  assign w_rr_next = (w_cur == N_W'(N_MANAGERS - 1)) ? '0 : w_cur + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i)       r_rr_ptr <= '0;
    else if (w_done) r_rr_ptr <= w_rr_next;
  end

  assign w_rr_ptr = r_rr_ptr;
`else
  logic w_unused_done;
  assign w_unused_done = w_done;
  assign w_rr_ptr      = '0;
`endif

  assign s_iob_valid_o = w_fwd;
  assign s_iob_addr_o  = m_iob_addr_i[int'(w_cur)*ADDR_W +: ADDR_W];
  assign s_iob_wdata_o = m_iob_wdata_i[int'(w_cur)*DATA_W +: DATA_W];
  assign s_iob_wstrb_o = m_iob_wstrb_i[int'(w_cur)*STRB_W +: STRB_W];

  always_comb begin
    m_iob_ready_o  = '0;
    m_iob_rvalid_o = '0;
    m_iob_rdata_o  = '0;
    if (w_fwd) m_iob_ready_o[w_cur] = s_iob_ready_i;
    m_iob_rvalid_o[w_cur] = w_route_rv;
    m_iob_rdata_o[int'(w_cur)*DATA_W +: DATA_W] = s_iob_rdata_i;
  end

  // Idle with no requester reports the last owner rather than the resting select index.
  assign grant_o = ((r_state == IDLE) && !w_any_valid) ? r_owner : w_cur;
  assign busy_o  = (r_state != IDLE);

endmodule

// File: tb/tb_iob_pbus_arbiter.sv
// Self-checking bench for iob_pbus_arbiter (N=2): directed table, corner sequences, randomized model run.
module tb_iob_pbus_arbiter;

`ifdef IOB_PBUS_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_valid;
  logic [27:0] m_addr;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic [1:0]  m_rvalid;
  logic [63:0] m_rdata;
  logic [1:0]  m_ready;
  logic        s_valid;
  logic [13:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        s_ready;
  logic [0:0]  grant;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  iob_pbus_arbiter #(.N_MANAGERS(2), .ADDR_W(14), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .m_iob_valid_i(m_valid), .m_iob_addr_i(m_addr), .m_iob_wdata_i(m_wdata),
    .m_iob_wstrb_i(m_wstrb), .m_iob_rvalid_o(m_rvalid), .m_iob_rdata_o(m_rdata),
    .m_iob_ready_o(m_ready), .s_iob_valid_o(s_valid), .s_iob_addr_o(s_addr),
    .s_iob_wdata_o(s_wdata), .s_iob_wstrb_o(s_wstrb), .s_iob_rvalid_i(s_rvalid),
    .s_iob_rdata_i(s_rdata), .s_iob_ready_i(s_ready), .grant_o(grant), .busy_o(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m_valid = '0; m_wstrb = '0; s_ready = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] v, input logic [1:0] wr, input logic rdy,
                       input logic rv, input logic [31:0] rd);
    m_valid  = v;
    m_addr   = {14'h2000, 14'h0010};
    m_wdata  = {32'h2222_2222, 32'h1111_1111};
    m_wstrb  = {wr[1] ? 4'hF : 4'h0, wr[0] ? 4'hF : 4'h0};
    s_ready  = rdy;
    s_rvalid = rv;
    s_rdata  = rd;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic expect_cyc(input string nm, input logic sv, input logic [1:0] rdy,
                            input logic [1:0] rv, input logic b, input logic g);
    chk({nm, ".s_valid"}, 64'(s_valid), 64'(sv));
    chk({nm, ".m_ready"}, 64'(m_ready), 64'(rdy));
    chk({nm, ".m_rvalid"}, 64'(m_rvalid), 64'(rv));
    chk({nm, ".busy"}, 64'(busy), 64'(b));
    chk({nm, ".grant"}, 64'(grant), 64'(g));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  v;
    logic [1:0]  wr;
    logic        rdy;
    logic        rv;
    logic [31:0] rd;
    logic        e_sv;
    logic [1:0]  e_rdy;
    logic [1:0]  e_rv;
    logic        e_busy;
    logic        e_gnt;
  } vec_t;

  vec_t tbl[10];

  // ---------------- reference model (transaction level) ----------------
  // phase: 0 free, 1 granted but waiting for ready, 2 waiting for read data
  int md_phase, md_owner, md_next;

  task automatic model_reset();
    md_phase = 0; md_owner = 0; md_next = 0;
  endtask

  task automatic model_check_cycle();
    int  start, cur;
    bit  any, wr, done, started;
    int  nphase;
    logic       e_sv;
    logic [1:0] e_rdy, e_rv;
    logic [31:0] other;
    any = 0; done = 0; started = 0; e_sv = 0; e_rdy = '0; e_rv = '0;
    nphase = md_phase;
    if (md_phase == 0) begin
      start = RR ? md_next : 0;
      cur = start;
      for (int i = 0; i < 2; i++)
        if (!any && m_valid[(start + i) % 2]) begin any = 1; cur = (start + i) % 2; end
    end else cur = md_owner;
    wr = (m_wstrb[cur*4 +: 4] != 4'h0);
    if (md_phase != 2) begin
      if (m_valid[cur]) begin
        started = 1; e_sv = 1; e_rdy[cur] = s_ready;
        if (s_ready && (wr || s_rvalid)) begin
          done = 1; nphase = 0;
          if (!wr) e_rv[cur] = 1'b1;
        end else nphase = s_ready ? 2 : 1;
      end else nphase = 0;
    end else if (s_rvalid) begin
      e_rv[cur] = 1'b1; done = 1; nphase = 0;
    end
    chk("rnd.s_valid", 64'(s_valid), 64'(e_sv));
    chk("rnd.m_ready", 64'(m_ready), 64'(e_rdy));
    chk("rnd.m_rvalid", 64'(m_rvalid), 64'(e_rv));
    chk("rnd.busy", 64'(busy), 64'(md_phase != 0));
    chk("rnd.grant", 64'(grant), 64'((md_phase == 0 && !any) ? md_owner : cur));
    if (e_sv) begin
      chk("rnd.s_addr", 64'(s_addr), 64'(m_addr[cur*14 +: 14]));
      chk("rnd.s_wdata", 64'(s_wdata), 64'(m_wdata[cur*32 +: 32]));
      chk("rnd.s_wstrb", 64'(s_wstrb), 64'(m_wstrb[cur*4 +: 4]));
    end
    other = m_rdata[(1 - cur)*32 +: 32];
    chk("rnd.rdata_other", 64'(other), 64'h0);
    if (e_rv != 2'b00) exp_q.push_back({1'(cur), s_rdata});
    if (started) md_owner = cur;
    if (done && RR) md_next = (cur + 1) % 2;
    md_phase = nphase;
  endtask

  // Scoreboard: every observed read-data pulse must match the oldest expected completion.
  task automatic score_rdata();
    logic [32:0] e;
    int idx;
    if (m_rvalid != 2'b00) begin
      idx = m_rvalid[1] ? 1 : 0;
      if (exp_q.size() == 0) begin
        chk("sb.unexpected_rvalid", 64'(m_rvalid), 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("sb.rvalid_idx", 64'(idx), 64'(e[32]));
        chk("sb.rdata", 64'(m_rdata[idx*32 +: 32]), 64'(e[31:0]));
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    expect_cyc("reset", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // single write, single read, then contention
    tbl[0] = '{2'b01, 2'b01, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[1] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[2] = '{2'b10, 2'b00, 1'b1, 1'b0, 32'h0,         1'b1, 2'b10, 2'b00, 1'b0, 1'b1};
    tbl[3] = '{2'b00, 2'b00, 1'b0, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[4] = '{2'b01, 2'b01, 1'b1, 1'b0, 32'h0,         1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
    tbl[5] = '{2'b01, 2'b01, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 2'b00, 2'b10, 1'b1, 1'b1};
    tbl[6] = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         1'b1, RR ? 2'b10 : 2'b01, 2'b00, 1'b0, RR};
    tbl[8] = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         1'b1, 2'b01, 2'b00, 1'b0, 1'b0};
    tbl[9] = '{2'b11, 2'b11, 1'b1, 1'b0, 32'h0,         1'b1, RR ? 2'b10 : 2'b01, 2'b00, 1'b0, RR};

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].wr, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      #2;
      expect_cyc($sformatf("tbl%0d", i), tbl[i].e_sv, tbl[i].e_rdy, tbl[i].e_rv,
                 tbl[i].e_busy, tbl[i].e_gnt);
      chk($sformatf("tbl%0d.rdata_other", i), 64'(m_rdata[(1 - tbl[i].e_gnt)*32 +: 32]), 64'h0);
      if (tbl[i].e_sv)
        chk($sformatf("tbl%0d.s_addr", i), 64'(s_addr), tbl[i].e_gnt ? 64'h2000 : 64'h0010);
      if (tbl[i].e_rv != 2'b00)
        chk($sformatf("tbl%0d.rdata", i), 64'(m_rdata[tbl[i].e_gnt*32 +: 32]), 64'(tbl[i].rd));
      @(negedge clk);
    end

    // held ready=0: grant stays with M0 while M1 waits
    do_reset();
    drive(2'b01, 2'b01, 1'b0, 1'b0, 32'h0); #2;
    expect_cyc("hold.c0", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int c = 1; c < 4; c++) begin
      @(negedge clk); drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0); #2;
      expect_cyc($sformatf("hold.c%0d", c), 1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
      chk($sformatf("hold.c%0d.s_addr", c), 64'(s_addr), 64'h0010);
    end
    @(negedge clk); drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0); #2;
    expect_cyc("hold.c4", 1'b1, 2'b01, 2'b00, 1'b1, 1'b0);
    @(negedge clk); drive(2'b10, 2'b10, 1'b1, 1'b0, 32'h0); #2;
    expect_cyc("hold.c5", 1'b1, 2'b10, 2'b00, 1'b0, 1'b1);

    // reset while waiting for read data; late rvalid must be dropped
    do_reset();
    drive(2'b01, 2'b00, 1'b1, 1'b0, 32'h0); #2;
    expect_cyc("rstrd.c0", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);
    @(negedge clk); drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0); #2;
    chk("rstrd.busy", 64'(busy), 64'h1);
    do_reset();
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0); #2;
    expect_cyc("rstrd.c1", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk); drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h1234_5678); #2;
    expect_cyc("rstrd.late", 1'b0, 2'b00, 2'b00, 1'b0, 1'b0);

    // owner withdraws in WAIT_READY: abandon, round-robin pointer untouched
    do_reset();
    drive(2'b01, 2'b01, 1'b0, 1'b0, 32'h0); #2;
    expect_cyc("drop.c0", 1'b1, 2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk); drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0); #2;
    expect_cyc("drop.c1", 1'b0, 2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge clk); drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0); #2;
    chk("drop.c2.busy", 64'(busy), 64'h0);
    @(negedge clk); drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0); #2;
    expect_cyc("drop.c3", 1'b1, 2'b01, 2'b00, 1'b0, 1'b0);

    // randomized run against the transaction-level model
    do_reset();
    model_reset();
    for (int c = 0; c < 500; c++) begin
      m_valid  = 2'($urandom_range(0, 3));
      m_addr   = {14'($urandom), 14'($urandom)};
      m_wdata  = {$urandom, $urandom};
      m_wstrb  = {($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0,
                  ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0};
      s_ready  = ($urandom_range(0, 2) != 0);
      s_rvalid = ($urandom_range(0, 2) == 0);
      s_rdata  = $urandom;
      #2;
      model_check_cycle();
      score_rdata();
      @(negedge clk);
    end
    chk("sb.drained", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
